uart_sram_bridge: RTL and testbench
===================================

UART_SRAM_BRIDGE -- requirements
Module: uart_sram_bridge

Interface
REQ-001 Parameter DATA_W, default 32: SRAM word width in bits; SHALL be a multiple of 8, 8..64.
REQ-002 Parameter ADDR_W, default 4: SRAM address width, 1..16; ADDR_BYTES = ceil(ADDR_W/8).
REQ-003 Parameter READ_LAT, default 1: cycles from read strobe to valid sram_dout, 1..3.
REQ-004 Parameter TIMEOUT_CYC, default 1_000_000: idle cycles between RX bytes before a frame is abandoned.
REQ-005 Ports SHALL be:
- clk  in  1  the single clock
- rst_n  in  1  asynchronous, active-low reset
- rx_data  in  8  byte from the UART receiver
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  bridge accepts a byte
- tx_data  out  8  byte to the UART transmitter
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  transmitter accepts the byte
- csb_n  out  1  SRAM chip select, active low
- we_n  out  1  SRAM write enable, active low
- sram_addr  out  ADDR_W  SRAM address
- sram_din  out  DATA_W  SRAM write data
- sram_dout  in  DATA_W  SRAM read data
- busy  out  1  high whenever the state is not IDLE
- err_pulse  out  1  one-cycle pulse on NAK or timeout

Function
REQ-006 An RX byte SHALL be consumed only in a cycle with rx_valid && rx_ready; a TX byte SHALL be transferred only in a cycle with tx_valid && tx_ready, and tx_data SHALL stay stable while tx_valid is high and tx_ready is low.
REQ-007 Frame format: CMD byte, then ADDR_BYTES address bytes, MSB first; CMD[7]=1 write, 0 read; CMD[6:4] reserved and must be 0; CMD[3:0] = burst length minus 1 (1..16 words).
REQ-008 Only the low ADDR_W bits of the assembled address SHALL be used.
REQ-009 A write frame SHALL carry len*DATA_W/8 data bytes, MSB first per word; each word SHALL be written as one cycle with csb_n=0, we_n=0, sram_addr and sram_din valid, issued in the cycle after its last byte is consumed.
REQ-010 After the final word of a write burst, the bridge SHALL transmit ACK 0xA5.
REQ-011 A read frame SHALL issue one cycle with csb_n=0, we_n=1 per word, sample sram_dout exactly READ_LAT cycles later, and transmit the word MSB first; the next read strobe SHALL not issue until the previous word is fully transmitted.
REQ-012 The address SHALL increment by 1 after each word and wrap from 2^ADDR_W-1 to 0.
REQ-013 A CMD byte with nonzero CMD[6:4] SHALL cause transmission of NAK 0x5A and a single err_pulse, with no SRAM access; the bridge then returns to IDLE.
REQ-014 rx_ready SHALL be high only in IDLE, ADDR and WDATA; it SHALL be low during SRAM strobes and transmissions.
REQ-015 If TIMEOUT_CYC cycles elapse in ADDR or WDATA without a consumed byte, the partial word SHALL be discarded, no further SRAM access SHALL occur, err_pulse SHALL fire, and the state SHALL return to IDLE; words already written stay written.
REQ-016 States: IDLE -> ADDR -> (WDATA <-> WSTROBE) -> ACK -> IDLE for writes; ADDR -> RSTROBE -> RWAIT -> RSEND -> (RSTROBE | IDLE) for reads; IDLE -> NAK -> IDLE for bad commands.
REQ-017 csb_n SHALL be low only in strobe cycles; otherwise csb_n=1 and we_n=1.

Reset
REQ-018 While rst_n=0: state IDLE, rx_ready=0, tx_valid=0, tx_data=0, csb_n=1, we_n=1, sram_addr=0, sram_din=0, busy=0, err_pulse=0, all counters 0.
REQ-019 Reset mid-frame SHALL abort the frame immediately, including tx_valid and any strobe; rx_ready SHALL rise in the first clock after rst_n deasserts.

Structure
REQ-020 Package uart_sram_pkg SHALL hold the state enum, ACK_BYTE=0xA5, NAK_BYTE=0x5A and the CMD field positions.
REQ-021 One sub-module, sram_word_shifter (byte-to-word pack and word-to-byte unpack, parametrised by DATA_W), SHALL be used; everything else is in uart_sram_bridge.

Verification (DATA_W=32, ADDR_W=4, READ_LAT=1)
REQ-022 RX 80 03 DE AD BE EF -> one strobe with addr=3, din=DEADBEEF, we_n=0; then TX A5.
REQ-023 RX 00 03 after REQ-022 -> one read strobe at addr 3; TX DE AD BE EF, also with tx_ready held low for 5 cycles per byte.
REQ-024 RX 81 0F plus 8 data bytes 11111111 22222222 -> writes to addr 15 then addr 0 (wrap); TX A5.
REQ-025 RX 40 -> TX 5A, one err_pulse, csb_n stays 1.
REQ-026 RX 80 03 DE, then idle TIMEOUT_CYC cycles -> no strobe, err_pulse, busy=0; a following valid frame completes normally.
REQ-027 rst_n=0 during the second TX byte of a read -> tx_valid=0 in the same cycle; after release, rx_ready=1 and state is IDLE.

Source files
------------

// File: rtl/uart_sram_pkg.sv
// Shared types and constants for the UART-to-SRAM bridge.
package uart_sram_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    WDATA,
    WSTROBE,
    ACK,
    RSTROBE,
    RWAIT,
    RSEND,
    NAK
  } state_t;

  localparam logic [7:0] ACK_BYTE = 8'hA5;
  localparam logic [7:0] NAK_BYTE = 8'h5A;

  // Command byte layout
  localparam int unsigned CMD_WR_BIT = 7;
  localparam int unsigned CMD_RSV_HI = 6;
  localparam int unsigned CMD_RSV_LO = 4;
  localparam int unsigned CMD_LEN_HI = 3;
  localparam int unsigned CMD_LEN_LO = 0;

endpackage

// File: rtl/sram_word_shifter.sv
// Byte-to-word packer and word-to-byte unpacker, MSB first.
module sram_word_shifter #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              shift_in,
  input  logic [7:0]        byte_in,
  input  logic              load,
  input  logic [DATA_W-1:0] word_in,
  input  logic              shift_out,
  output logic [DATA_W-1:0] word,
  output logic [7:0]        byte_out
);

  // Word register: parallel load for reads, shift in/out a byte at a time
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         word <= '0;
    else if (load)      word <= word_in;
    else if (shift_in)  word <= (word << 8) | DATA_W'(byte_in);
    else if (shift_out) word <= word << 8;
  end

  assign byte_out = word[DATA_W-1 -: 8];

endmodule

// File: rtl/uart_sram_bridge.sv
// Command bridge between a byte-wide UART link and a synchronous SRAM.
module uart_sram_bridge
  import uart_sram_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 4,
  parameter int READ_LAT    = 1,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              csb_n,
  output logic              we_n,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_din,
  input  logic [DATA_W-1:0] sram_dout,
  output logic              busy,
  output logic              err_pulse
);

  localparam int          ADDR_BYTES = (ADDR_W + 7) / 8;
  localparam int unsigned TW         = $clog2(TIMEOUT_CYC + 1);
  localparam logic [2:0]  BYTE_LAST  = 3'(DATA_W / 8 - 1);
  localparam logic        ABYTE_LAST = 1'(ADDR_BYTES - 1);
  localparam logic [1:0]  LAT_LAST   = 2'(READ_LAT);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  state_t            state, state_nxt;
  logic              alive;
  logic              wr;
  logic [3:0]        len_m1;
  logic [ADDR_W-1:0] addr;
  logic              abyte_cnt;
  logic [2:0]        byte_cnt;
  logic [3:0]        word_cnt;
  logic [1:0]        lat_cnt;
  logic [TW-1:0]     tmo_cnt;
  logic              rx_fire, tx_fire, tmo_hit, timeout, bad_cmd;
  logic              sh_in, sh_load, sh_out;
  logic [7:0]        byte_out;

  sram_word_shifter #(.DATA_W(DATA_W)) u_shifter (
    .clk       (clk),
    .rst_n     (rst_n),
    .shift_in  (sh_in),
    .byte_in   (rx_data),
    .load      (sh_load),
    .word_in   (sram_dout),
    .shift_out (sh_out),
    .word      (sram_din),
    .byte_out  (byte_out)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Outputs decoded from state, then next-state selection
  always_comb begin
    rx_ready  = 1'b0;
    tx_valid  = 1'b0;
    tx_data   = '0;
    csb_n     = 1'b1;
    we_n      = 1'b1;
    case (state)
      IDLE, ADDR, WDATA: rx_ready = alive;
      WSTROBE: begin csb_n = 1'b0; we_n = 1'b0; end
      RSTROBE: csb_n = 1'b0;
      ACK:     begin tx_valid = 1'b1; tx_data = ACK_BYTE; end
      NAK:     begin tx_valid = 1'b1; tx_data = NAK_BYTE; end
      RSEND:   begin tx_valid = 1'b1; tx_data = byte_out; end
      default: ;
    endcase

    rx_fire   = rx_valid && rx_ready;
    tx_fire   = tx_valid && tx_ready;
    tmo_hit   = (tmo_cnt == TMO_LAST);
    timeout   = 1'b0;
    bad_cmd   = 1'b0;
    state_nxt = state;
    case (state)
      IDLE: if (rx_fire) begin
        if (rx_data[CMD_RSV_HI:CMD_RSV_LO] != '0) begin
          bad_cmd   = 1'b1;
          state_nxt = NAK;
        end else begin
          state_nxt = ADDR;
        end
      end
      ADDR: begin
        if (rx_fire) begin
          if (abyte_cnt == ABYTE_LAST) state_nxt = wr ? WDATA : RSTROBE;
        end else if (tmo_hit) begin
          timeout   = 1'b1;
          state_nxt = IDLE;
        end
      end
      WDATA: begin
        if (rx_fire) begin
          if (byte_cnt == BYTE_LAST) state_nxt = WSTROBE;
        end else if (tmo_hit) begin
          timeout   = 1'b1;
          state_nxt = IDLE;
        end
      end
      WSTROBE: state_nxt = (word_cnt == len_m1) ? ACK : WDATA;
      ACK, NAK: if (tx_fire) state_nxt = IDLE;
      RSTROBE:  state_nxt = RWAIT;
      RWAIT:    if (lat_cnt == LAT_LAST) state_nxt = RSEND;
      RSEND: if (tx_fire && byte_cnt == BYTE_LAST)
        state_nxt = (word_cnt == len_m1) ? IDLE : RSTROBE;
      default: state_nxt = IDLE;
    endcase

    sh_in   = (state == WDATA) && rx_fire;
    sh_load = (state == RWAIT) && (lat_cnt == LAT_LAST);
    sh_out  = (state == RSEND) && tx_fire;
  end

  // Frame bookkeeping: command fields, address, byte/word/latency/idle counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alive     <= 1'b0;
      wr        <= 1'b0;
      len_m1    <= '0;
      addr      <= '0;
      abyte_cnt <= '0;
      byte_cnt  <= '0;
      word_cnt  <= '0;
      lat_cnt   <= '0;
      tmo_cnt   <= '0;
      err_pulse <= 1'b0;
    end else begin
      alive     <= 1'b1;
      err_pulse <= bad_cmd || timeout;
      if ((state == ADDR || state == WDATA) && !rx_fire && !timeout)
        tmo_cnt <= tmo_cnt + 1'b1;
      else
        tmo_cnt <= '0;
      case (state)
        IDLE: if (rx_fire) begin
          wr        <= rx_data[CMD_WR_BIT];
          len_m1    <= rx_data[CMD_LEN_HI:CMD_LEN_LO];
          abyte_cnt <= '0;
          byte_cnt  <= '0;
          word_cnt  <= '0;
        end
        // Shifting whole bytes in and truncating keeps exactly the low ADDR_W bits
        ADDR: if (rx_fire) begin
          addr      <= ADDR_W'({addr, rx_data});
          abyte_cnt <= abyte_cnt + 1'b1;
        end
        WDATA: if (rx_fire) byte_cnt <= (byte_cnt == BYTE_LAST) ? '0 : byte_cnt + 1'b1;
        WSTROBE: begin
          addr     <= addr + 1'b1;
          word_cnt <= word_cnt + 1'b1;
        end
        RSTROBE: begin
          addr    <= addr + 1'b1;
          lat_cnt <= 2'd1;
        end
        RWAIT: lat_cnt <= lat_cnt + 1'b1;
        RSEND: if (tx_fire) begin
          if (byte_cnt == BYTE_LAST) begin
            byte_cnt <= '0;
            word_cnt <= word_cnt + 1'b1;
          end else begin
            byte_cnt <= byte_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign sram_addr = addr;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_uart_sram_bridge.sv
// Scoreboard bench for uart_sram_bridge with a behavioural SRAM.
module tb_uart_sram_bridge;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int RL = 1;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          csb_n, we_n;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_din, sram_dout;
  logic          busy, err_pulse;

  always #5 clk = ~clk;

  uart_sram_bridge #(.DATA_W(DW), .ADDR_W(AW), .READ_LAT(RL), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .csb_n(csb_n), .we_n(we_n),
    .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout), .busy(busy),
    .err_pulse(err_pulse)
  );

  // Synchronous SRAM, one cycle read latency
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (!csb_n) begin
      if (!we_n) mem[sram_addr] <= sram_din;
      else       sram_dout <= mem[sram_addr];
    end
  end

  logic [7:0]       exp_tx [$];
  logic [AW+DW-1:0] exp_wr [$];
  logic [AW-1:0]    exp_rd [$];
  int total = 0, bad = 0, strobes = 0, errs = 0, tx_cnt = 0;
  logic             hold_v = 1'b0;
  logic [7:0]       hold_d, e8;
  logic [AW+DW-1:0] ewr;
  logic [AW-1:0]    erd;

  // Monitor: pops the scoreboard on every transfer and strobe
  always @(negedge clk) begin
    if (err_pulse) errs++;
    if (hold_v && tx_valid) begin
      total++;
      if (tx_data !== hold_d) begin
        bad++;
        $display("FAIL tx_stable: tx_data=%02h while stalled, required %02h", tx_data, hold_d);
      end
    end
    hold_v = tx_valid && !tx_ready;
    hold_d = tx_data;
    if (tx_valid && tx_ready) begin
      tx_cnt++; total++;
      if (exp_tx.size() == 0) begin
        bad++; $display("FAIL tx_byte: got %02h, required no transfer", tx_data);
      end else begin
        e8 = exp_tx.pop_front();
        if (tx_data !== e8) begin
          bad++; $display("FAIL tx_byte: got %02h, required %02h", tx_data, e8);
        end
      end
    end
    if (!csb_n) begin
      strobes++; total++;
      if (!we_n) begin
        if (exp_wr.size() == 0) begin
          bad++; $display("FAIL wr_strobe: addr=%0h din=%08h, required no write", sram_addr, sram_din);
        end else begin
          ewr = exp_wr.pop_front();
          if ({sram_addr, sram_din} !== ewr) begin
            bad++;
            $display("FAIL wr_strobe: addr=%0h din=%08h, required addr=%0h din=%08h",
                     sram_addr, sram_din, ewr[AW+DW-1:DW], ewr[DW-1:0]);
          end
        end
      end else begin
        if (exp_rd.size() == 0) begin
          bad++; $display("FAIL rd_strobe: addr=%0h, required no read", sram_addr);
        end else begin
          erd = exp_rd.pop_front();
          if (sram_addr !== erd) begin
            bad++; $display("FAIL rd_strobe: addr=%0h, required %0h", sram_addr, erd);
          end
        end
      end
    end
  end

  // TX sink: ready always, or 5 stalled cycles per byte
  logic stall_mode = 1'b0;
  int   stall_cnt  = 0;
  initial begin
    tx_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!stall_mode)          tx_ready = 1'b1;
      else if (!tx_valid)       begin tx_ready = 1'b0; stall_cnt = 0; end
      else if (stall_cnt < 5)   begin tx_ready = 1'b0; stall_cnt++; end
      else                      begin tx_ready = 1'b1; stall_cnt = 0; end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int   n = 0;
    logic got = 1'b0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!got && n < 200) begin
      @(negedge clk); got = rx_ready;
      @(posedge clk); #1; n++;
    end
    rx_valid = 1'b0;
    total++;
    if (!got) begin
      bad++; $display("FAIL rx_accept: byte %02h not taken in 200 cycles, required accept", b);
    end
  endtask

  task automatic push_word_tx(input logic [DW-1:0] w);
    for (int unsigned i = 0; i < DW/8; i++) exp_tx.push_back(w[DW-1-8*i -: 8]);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    @(negedge clk);
    while ((busy || exp_tx.size() != 0 || exp_wr.size() != 0 || exp_rd.size() != 0) && n < 2000) begin
      @(negedge clk); n++;
    end
    total++;
    if (n >= 2000) begin
      bad++;
      $display("FAIL %s: still pending busy=%0b tx=%0d wr=%0d rd=%0d, required all 0",
               name, busy, exp_tx.size(), exp_wr.size(), exp_rd.size());
      exp_tx.delete(); exp_wr.delete(); exp_rd.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rx_valid = 1'b0; rx_data = '0;
    repeat (3) @(negedge clk);
    total++;
    if ({rx_ready, tx_valid, tx_data, csb_n, we_n, sram_addr, sram_din, busy, err_pulse} !==
        {1'b0, 1'b0, 8'h00, 1'b1, 1'b1, {AW{1'b0}}, {DW{1'b0}}, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_state: rdy=%0b txv=%0b txd=%02h csb=%0b we=%0b a=%0h d=%08h busy=%0b err=%0b, required 0 0 00 1 1 0 0 0 0",
               rx_ready, tx_valid, tx_data, csb_n, we_n, sram_addr, sram_din, busy, err_pulse);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (rx_ready !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL reset_release: rx_ready=%0b busy=%0b, required 1 0", rx_ready, busy);
    end
  endtask

  task automatic test_write();
    exp_wr.push_back({4'h3, 32'hDEADBEEF});
    exp_tx.push_back(8'hA5);
    send_byte(8'h80); send_byte(8'h03);
    send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
    wait_done("write_single");
  endtask

  task automatic test_read();
    exp_rd.push_back(4'h3); push_word_tx(32'hDEADBEEF);
    send_byte(8'h00); send_byte(8'h03);
    wait_done("read_single");
    stall_mode = 1'b1;
    exp_rd.push_back(4'h3); push_word_tx(32'hDEADBEEF);
    send_byte(8'h00); send_byte(8'h03);
    wait_done("read_stalled");
    stall_mode = 1'b0;
  endtask

  task automatic test_wrap();
    exp_wr.push_back({4'hF, 32'h11111111});
    exp_wr.push_back({4'h0, 32'h22222222});
    exp_tx.push_back(8'hA5);
    send_byte(8'h81); send_byte(8'h0F);
    for (int unsigned i = 0; i < 4; i++) send_byte(8'h11);
    for (int unsigned i = 0; i < 4; i++) send_byte(8'h22);
    wait_done("write_wrap");
    exp_rd.push_back(4'hF); exp_rd.push_back(4'h0);
    push_word_tx(32'h11111111); push_word_tx(32'h22222222);
    send_byte(8'h01); send_byte(8'h0F);
    wait_done("read_wrap");
  endtask

  task automatic test_nak();
    int e0 = errs, s0 = strobes;
    exp_tx.push_back(8'h5A);
    send_byte(8'h40);
    wait_done("nak");
    total++;
    if (errs !== e0 + 1 || strobes !== s0) begin
      bad++; $display("FAIL nak_err: err cycles=%0d strobes=%0d, required 1 0", errs - e0, strobes - s0);
    end
  endtask

  task automatic test_timeout();
    int e0 = errs, s0 = strobes;
    send_byte(8'h80); send_byte(8'h03); send_byte(8'hDE);
    repeat (TO - 4) @(negedge clk);
    total++;
    if (busy !== 1'b1 || errs !== e0) begin
      bad++; $display("FAIL timeout_early: busy=%0b err cycles=%0d, required 1 0", busy, errs - e0);
    end
    repeat (8) @(negedge clk);
    total++;
    if (busy !== 1'b0 || errs !== e0 + 1 || strobes !== s0) begin
      bad++;
      $display("FAIL timeout_abort: busy=%0b err cycles=%0d strobes=%0d, required 0 1 0",
               busy, errs - e0, strobes - s0);
    end
    @(posedge clk); #1;
    exp_wr.push_back({4'h5, 32'hCAFEF00D}); exp_tx.push_back(8'hA5);
    send_byte(8'h80); send_byte(8'h05);
    send_byte(8'hCA); send_byte(8'hFE); send_byte(8'hF0); send_byte(8'h0D);
    wait_done("after_timeout_write");
    exp_rd.push_back(4'h5); push_word_tx(32'hCAFEF00D);
    send_byte(8'h00); send_byte(8'h05);
    wait_done("after_timeout_read");
  endtask

  task automatic test_reset_mid();
    int t0 = tx_cnt, n = 0;
    stall_mode = 1'b1;
    exp_rd.push_back(4'h3); exp_tx.push_back(8'hDE);
    send_byte(8'h00); send_byte(8'h03);
    while (tx_cnt < t0 + 1 && n < 500) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    total++;
    if (tx_valid !== 1'b1) begin
      bad++; $display("FAIL mid_precond: tx_valid=%0b on second byte, required 1", tx_valid);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (tx_valid !== 1'b0 || csb_n !== 1'b1 || busy !== 1'b0 || rx_ready !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset: tx_valid=%0b csb_n=%0b busy=%0b rx_ready=%0b, required 0 1 0 0",
               tx_valid, csb_n, busy, rx_ready);
    end
    stall_mode = 1'b0;
    total++;
    if (exp_tx.size() != 0 || exp_rd.size() != 0) begin
      bad++; $display("FAIL mid_scoreboard: tx left=%0d rd left=%0d, required 0 0", exp_tx.size(), exp_rd.size());
      exp_tx.delete(); exp_rd.delete();
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (rx_ready !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL mid_release: rx_ready=%0b busy=%0b, required 1 0", rx_ready, busy);
    end
    exp_rd.push_back(4'h3); push_word_tx(32'hDEADBEEF);
    send_byte(8'h00); send_byte(8'h03);
    wait_done("read_after_reset");
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_wrap();
    test_nak();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
